m_ext_sequencer: RTL
====================

# m_ext_sequencer

Control sequencer for the RV32M multiply/divide datapath in the execute stage. It accepts one M-extension operation at a time from issue over a valid/ready handshake and drives the shared datapath's operands, opcode and one-cycle divider start pulse. It waits for the multi-cycle divider, resolves RISC-V divide special cases without starting the divider, and returns one result per request over a valid/ready handshake. Flush, divider drain and a divider watchdog are also handled here.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- MAX_DIV_CYCLES, 40, watchdog limit on cycles spent waiting for divider ready
- RD_WIDTH, 5, destination register tag width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  issue presents an M operation
- req_ready  out  1  sequencer accepts this cycle
- req_funct3  in  3  MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
- req_s1, req_s2  in  DATA_WIDTH  operands
- req_rd  in  RD_WIDTH  destination tag
- flush  in  1  kill in-flight operation
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_data  out  DATA_WIDTH  result
- resp_rd  out  RD_WIDTH  tag of result
- busy  out  1  state != IDLE
- div_timeout  out  1  one-cycle pulse on watchdog expiry
- dp_s1, dp_s2  out  DATA_WIDTH  registered operands to datapath
- dp_op  out  3  registered funct3 to datapath
- dp_div_start  out  1  divider start pulse
- dp_div_ready  in  1  divider result valid
- dp_result  in  DATA_WIDTH  datapath selected result

## Operation
- States: IDLE, MUL, DIV_START, DIV_WAIT, DRAIN, RESP.
- req_ready = (state==IDLE) & !flush.
- Accept means req_valid & req_ready. On accept, register s1, s2, funct3 and rd.
- Routing on accept:
  - funct3[2]==0 → MUL.
  - Divide special case → RESP directly, with resp_data computed internally.
  - Otherwise → DIV_START.
- Divide special cases:
  - s2==0: DIV/DIVU → all-ones; REM/REMU → s1.
  - DIV/REM with s1==0x8000_0000 and s2==0xFFFF_FFFF: DIV → 0x8000_0000; REM → 0.
  - DIVU/REMU are never overflow cases.
- MUL: one cycle. Capture dp_result, then → RESP.
- DIV_START: dp_div_start=1 for exactly this cycle, then → DIV_WAIT. Watchdog counter cleared.
- DIV_WAIT:
  - dp_div_ready → capture dp_result, → RESP.
  - Counter reaching MAX_DIV_CYCLES → div_timeout pulse, resp_data=0, → RESP.
- RESP: resp_valid=1. resp_data and resp_rd stay stable until resp_ready, then → IDLE.
- Flush, by state:
  - MUL or RESP → IDLE; the result is dropped.
  - DIV_START or DIV_WAIT → DRAIN.
  - IDLE: nothing is accepted that cycle.
- DRAIN: req_ready=0 and no response. Wait for dp_div_ready (discard the result) or watchdog expiry (pulse div_timeout), then → IDLE.
- Flush while already in DRAIN: no effect.
- dp_div_ready outside DIV_WAIT/DRAIN is ignored.
- Flush has priority over dp_div_ready and over watchdog expiry in the same cycle; the state goes to DRAIN or IDLE as above.
- Reset, from any state including mid-divide:
  - state=IDLE; all outputs 0 (resp_valid, resp_data, resp_rd, busy, div_timeout, dp_*); counter=0.
  - req_ready is 1 after the first post-reset edge.
  - The divider is reset by the same reset, so no drain is needed.

## Timing
- All outputs are registered except req_ready, which is combinational from state and flush.
- MUL: accept at edge N, resp_valid high from edge N+2.
- Special-case divide: resp_valid from edge N+1.
- Normal divide: dp_div_start high during cycle N+1 to N+2. If dp_div_ready is seen in cycle M, resp_valid is high from edge M+1.
- Throughput: at most one operation in flight. The next accept is possible the cycle after the RESP handshake.
- Back-to-back: IDLE on edge K after a resp_ready handshake; accept during cycle K.

## Structure
- Define.v gets:
  - M funct3 constants (M_MUL … M_REMU)
  - state encodings (MSEQ_IDLE … MSEQ_RESP)
  - the DIV_OVF_S1 constant
- One combinational sub-module, m_div_special. Inputs: funct3, s1, s2. Outputs: is_special and special_result.
- The FSM, operand registers and watchdog counter stay in the top module.

## Test plan
- MUL s1=7, s2=6: accept at N → resp_valid at N+2, resp_data=42, dp_div_start never asserted.
- DIVU s1=100, s2=7, divider model ready 33 cycles after start: exactly one start pulse; resp_data=14 one cycle after ready. Repeat with REMU → 2.
- DIV s1=0x8000_0000, s2=0xFFFF_FFFF → resp_data=0x8000_0000 at N+1, no start. REMU s1=5, s2=0 → 5. DIVU s1=5, s2=0 → 0xFFFF_FFFF.
- Flush in DIV_WAIT cycle 5, then req_valid held: req_ready=0 until the model's ready, no resp_valid; the next request is accepted the cycle after the drain.
- Divider model never asserts ready: div_timeout pulses after 40 wait cycles; resp_valid with resp_data=0; return to IDLE.
- Hold resp_ready=0 for 10 cycles: resp_valid, resp_data and resp_rd stable, req_ready=0. Assert rst mid-divide: all outputs 0 next edge, req_ready=1.

Source files
------------

// File: rtl/m_ext_sequencer_pkg.sv
// Shared encodings for the RV32M sequencer: funct3 opcodes, FSM states and
// the signed-overflow dividend pattern.
package m_ext_sequencer_pkg;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_funct3_e;

  typedef enum logic [2:0] {
    MSEQ_IDLE      = 3'd0,
    MSEQ_MUL       = 3'd1,
    MSEQ_DIV_START = 3'd2,
    MSEQ_DIV_WAIT  = 3'd3,
    MSEQ_DRAIN     = 3'd4,
    MSEQ_RESP      = 3'd5
  } mseq_state_e;

  // Most negative RV32 value; only its sign bit matters when widening.
  localparam logic [31:0] DIV_OVF_S1 = 32'h8000_0000;

endpackage

// File: rtl/m_div_special.sv
// Resolves RISC-V divide corner cases (divide by zero, signed overflow) so the
// sequencer can answer them without starting the divider.
module m_div_special
  import m_ext_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] s1,
  input  logic [DATA_WIDTH-1:0] s2,
  output logic                  is_special,
  output logic [DATA_WIDTH-1:0] special_result
);

  localparam logic [DATA_WIDTH-1:0] OVF_S1 = {DIV_OVF_S1[31], {(DATA_WIDTH-1){1'b0}}};

  logic is_rem;
  logic is_signed;
  logic div_by_zero;
  logic signed_ovf;

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no
    // path through the ifs below can leave a value held, i.e. no latch.
    special_result = '0;
    is_rem         = (funct3 == M_REM) || (funct3 == M_REMU);
    is_signed      = (funct3 == M_DIV) || (funct3 == M_REM);
    div_by_zero    = (s2 == '0);
    signed_ovf     = is_signed && (s1 == OVF_S1) && (s2 == '1);
    is_special     = funct3[2] && (div_by_zero || signed_ovf);

    if (div_by_zero) begin
      special_result = is_rem ? s1 : '1;
    end else if (signed_ovf) begin
      special_result = is_rem ? '0 : OVF_S1;
    end
  end

endmodule

// File: rtl/m_ext_sequencer.sv
// Control sequencer for the shared RV32M multiply/divide datapath: one
// operation in flight, divider start/wait with watchdog, flush and drain.
module m_ext_sequencer
  import m_ext_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_DIV_CYCLES = 40,
  parameter int RD_WIDTH       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_s1,
  input  logic [DATA_WIDTH-1:0] req_s2,
  input  logic [RD_WIDTH-1:0]   req_rd,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [RD_WIDTH-1:0]   resp_rd,
  output logic                  busy,
  output logic                  div_timeout,
  output logic [DATA_WIDTH-1:0] dp_s1,
  output logic [DATA_WIDTH-1:0] dp_s2,
  output logic [2:0]            dp_op,
  output logic                  dp_div_start,
  input  logic                  dp_div_ready,
  input  logic [DATA_WIDTH-1:0] dp_result
);

  localparam int CNT_W = $clog2(MAX_DIV_CYCLES + 1);

  mseq_state_e           state_q;
  mseq_state_e           state_d;
  logic [CNT_W-1:0]      wd_cnt_q;
  logic                  accept;
  logic                  wd_expired;
  logic                  timeout_fire;
  logic                  is_special;
  logic [DATA_WIDTH-1:0] special_result;

  m_div_special #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_special (
    .funct3        (req_funct3),
    .s1            (req_s1),
    .s2            (req_s2),
    .is_special    (is_special),
    .special_result(special_result)
  );

  assign req_ready  = (state_q == MSEQ_IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  // >= rather than == so a flush landing on the expiry cycle still times out in DRAIN.
  assign wd_expired = (wd_cnt_q >= CNT_W'(MAX_DIV_CYCLES - 1));

  // Flush suppresses expiry in DIV_WAIT; DRAIN ignores flush entirely.
  assign timeout_fire = wd_expired && !dp_div_ready &&
                        (((state_q == MSEQ_DIV_WAIT) && !flush) || (state_q == MSEQ_DRAIN));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MSEQ_IDLE: begin
        if (accept) begin
          if (!req_funct3[2])  state_d = MSEQ_MUL;
          else if (is_special) state_d = MSEQ_RESP;
          else                 state_d = MSEQ_DIV_START;
        end
      end
      MSEQ_MUL:       state_d = flush ? MSEQ_IDLE : MSEQ_RESP;
      MSEQ_DIV_START: state_d = flush ? MSEQ_DRAIN : MSEQ_DIV_WAIT;
      MSEQ_DIV_WAIT: begin
        if (flush)                           state_d = MSEQ_DRAIN;
        else if (dp_div_ready || wd_expired) state_d = MSEQ_RESP;
      end
      MSEQ_DRAIN: begin
        if (dp_div_ready || wd_expired) state_d = MSEQ_IDLE;
      end
      MSEQ_RESP: begin
        if (flush || resp_ready) state_d = MSEQ_IDLE;
      end
      default: state_d = MSEQ_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order or process scheduling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MSEQ_IDLE;
      wd_cnt_q     <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_rd      <= '0;
      busy         <= 1'b0;
      div_timeout  <= 1'b0;
      dp_s1        <= '0;
      dp_s2        <= '0;
      dp_op        <= '0;
      dp_div_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d != MSEQ_IDLE);
      resp_valid   <= (state_d == MSEQ_RESP);
      dp_div_start <= (state_d == MSEQ_DIV_START);
      div_timeout  <= timeout_fire;

      if (accept) begin
        dp_s1   <= req_s1;
        dp_s2   <= req_s2;
        dp_op   <= req_funct3;
        resp_rd <= req_rd;
        if (req_funct3[2] && is_special) begin
          resp_data <= special_result;
        end
      end

      if ((state_q == MSEQ_MUL) && !flush) begin
        resp_data <= dp_result;
      end else if ((state_q == MSEQ_DIV_WAIT) && !flush) begin
        if (dp_div_ready)    resp_data <= dp_result;
        else if (wd_expired) resp_data <= '0;
      end

      // The watchdog counts cycles spent waiting on the divider, including drain.
      if (state_q == MSEQ_DIV_START) begin
        wd_cnt_q <= '0;
      end else if ((state_q == MSEQ_DIV_WAIT) || (state_q == MSEQ_DRAIN)) begin
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
